// File: rtl/trig_capture_buffer_pkg.sv
// Shared types for the triggered capture buffer: FSM state encoding and trigger modes.
package trig_capture_buffer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StPost,
    StDone
  } state_e;

  localparam logic [1:0] ModeImm      = 2'd0;
  localparam logic [1:0] ModeLevel    = 2'd1;
  localparam logic [1:0] ModeEdge     = 2'd2;
  localparam logic [1:0] ModeLevelAlt = 2'd3;

endpackage

// File: rtl/trig_capture_buffer_ram.sv
// Simple dual-port record RAM: one write port, one read port with a registered output.
module trig_capture_buffer_ram #(
  parameter int unsigned W      = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Storage itself is not reset; only the output register is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trig_capture_buffer.sv
// Triggered sample recorder: rate-divided sampling, masked level/edge trigger,
// DEPTH-sample record with pre-trigger history, read back in trigger-aligned order.
module trig_capture_buffer
  import trig_capture_buffer_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DIV_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [W-1:0]      pattern,
  input  logic [W-1:0]      mask,
  input  logic [ADDR_W-1:0] pre_cnt,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [W-1:0]      din,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [DIV_W-1:0]  DivOne  = DIV_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [W-1:0]      pattern_q, mask_q, din_q;
  logic [ADDR_W-1:0] pre_cnt_q;
  logic [DIV_W-1:0]  div_val_q, div_cnt_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, fill_q, fill_d, post_q, post_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d, rd_phys_q;
  logic              match_prev_q, match_prev_d;
  logic              triggered_q, triggered_d, done_q, done_d;
  logic              start_ok, tick, match, trig_hit, we;

  assign start_ok = start && !abort && (state_q == StIdle || state_q == StDone);
  assign tick     = (div_cnt_q == div_val_q);
  assign match    = (((din_q ^ pattern_q) & mask_q) == '0);

  always_comb begin
    case (mode_q)
      ModeImm:  trig_hit = 1'b1;
      ModeEdge: trig_hit = match && !match_prev_q;
      default:  trig_hit = match;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    post_d       = post_q;
    start_addr_d = start_addr_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    match_prev_d = tick ? match : match_prev_q;
    we           = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d     = StArm;
          wr_ptr_d    = '0;
          fill_d      = '0;
          triggered_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      StArm: begin
        // A level already matching when WAIT is entered must not count as an edge.
        if (fill_q == pre_cnt_q) begin
          state_d      = StWait;
          match_prev_d = 1'b1;
        end else if (tick) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrOne;
          fill_d   = fill_q + AddrOne;
          if (fill_q + AddrOne == pre_cnt_q) begin
            state_d      = StWait;
            match_prev_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (tick) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrOne;
          if (trig_hit) begin
            triggered_d  = 1'b1;
            start_addr_d = wr_ptr_q - pre_cnt_q;
            post_d       = AddrMax - pre_cnt_q;
            if (pre_cnt_q == AddrMax) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StPost;
            end
          end
        end
      end
      StPost: begin
        if (tick) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AddrOne;
          post_d   = post_q - AddrOne;
          if (post_q == AddrOne) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d     = StIdle;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      we          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      pattern_q    <= '0;
      mask_q       <= '0;
      pre_cnt_q    <= '0;
      div_val_q    <= '0;
      div_cnt_q    <= '0;
      din_q        <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      start_addr_q <= '0;
      rd_phys_q    <= '0;
      match_prev_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din;
      div_cnt_q    <= (start_ok || tick) ? '0 : div_cnt_q + DivOne;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      start_addr_q <= start_addr_d;
      rd_phys_q    <= rd_addr + start_addr_q;
      match_prev_q <= match_prev_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      if (start_ok) begin
        mode_q    <= mode;
        pattern_q <= pattern;
        mask_q    <= mask;
        pre_cnt_q <= pre_cnt;
        div_val_q <= div_val;
      end
    end
  end

  assign busy      = (state_q == StArm) || (state_q == StWait) || (state_q == StPost);
  assign triggered = triggered_q;
  assign done      = done_q;

  trig_capture_buffer_ram #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (din_q),
    .raddr (rd_phys_q),
    .rdata (rd_data)
  );

endmodule
